// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//   Bundles the control and status signals of the fetch-stage PC sequencer.
//   The master drives the control inputs and reads the status outputs. The
//   slave is the sequencer itself.
//
//   Master -> slave : stall, redirect_valid, redirect_target, trap_valid,
//                     trap_vector, halt_req, resume
//   Slave -> master : pc, pc_valid, pending_redirect, misaligned_fault,
//                     fault_addr
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int XLEN = 64
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            halt_req;
  logic            resume;

  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pending_redirect;
  logic            misaligned_fault;
  logic [XLEN-1:0] fault_addr;

  modport master (
    output stall, redirect_valid, redirect_target, trap_valid, trap_vector,
           halt_req, resume,
    input  pc, pc_valid, pending_redirect, misaligned_fault, fault_addr
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_valid, trap_vector,
           halt_req, resume,
    output pc, pc_valid, pending_redirect, misaligned_fault, fault_addr
  );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Holds the fetch PC and selects the next PC. The sources, from highest to
//   lowest priority, are the trap vector, a branch/jump redirect, a buffered
//   redirect, and the sequential increment. A redirect that arrives while fetch
//   is stalled, or while the sequencer is halted, is buffered. Any trap or
//   redirect target that is misaligned is rejected. A rejection pulses
//   misaligned_fault and records the target in fault_addr.
//
//   Ports:
//     clk    : clock; all state changes on the rising edge
//     reset  : asynchronous, active-high reset
//     bus    : pc_sequencer_if.slave; control in, pc/status out
//
//   Every output comes from a register or is decoded from registered state.
//   There is no combinational path from any input to pc.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Low-bit mask for the alignment check. An ALIGN_BITS of 0 gives an empty
  // mask, which disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(INC);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] faddr_q, faddr_d;

  logic trap_mis, redir_mis;

  assign trap_mis  = |(bus.trap_vector & ALIGN_MASK);
  assign redir_mis = |(bus.redirect_target & ALIGN_MASK);

  // ---------------------------------------------------------------------------
  // State register (FSM state plus the datapath registers)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      fault_q    <= 1'b0;
      faddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      fault_q    <= fault_d;
      faddr_q    <= faddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block. Without the
  // defaults, any path through the case/if tree that skips an assignment would
  // infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    fault_d    = 1'b0;
    faddr_d    = faddr_q;

    unique case (state_q)
      // The first edge out of reset only marks the reset vector as valid.
      S_BOOT: state_d = S_RUN;

      S_RUN: begin
        if (bus.trap_valid) begin
          if (trap_mis) begin
            fault_d = 1'b1;
            faddr_d = bus.trap_vector;
          end else begin
            pc_d       = bus.trap_vector;
            pend_d     = 1'b0;
            pend_tgt_d = '0;
          end
        end else if (bus.redirect_valid && !bus.stall) begin
          if (redir_mis) begin
            fault_d = 1'b1;
            faddr_d = bus.redirect_target;
          end else begin
            pc_d       = bus.redirect_target;
            pend_d     = 1'b0;
            pend_tgt_d = '0;
          end
        end else if (bus.redirect_valid) begin
          // Stalled: buffer the newest redirect. It overwrites any older one.
          if (redir_mis) begin
            fault_d = 1'b1;
            faddr_d = bus.redirect_target;
          end else begin
            pend_d     = 1'b1;
            pend_tgt_d = bus.redirect_target;
          end
        end else if (pend_q && !bus.stall) begin
          pc_d       = pend_tgt_q;
          pend_d     = 1'b0;
          pend_tgt_d = '0;
        end else if (!bus.stall) begin
          pc_d = pc_q + PC_INC;
        end

        // A trap takes precedence over halting, so the halt must be requested
        // again after the trap.
        if (bus.halt_req && !bus.trap_valid) state_d = S_HALT;
      end

      S_HALT: begin
        if (bus.trap_valid) begin
          if (trap_mis) begin
            fault_d = 1'b1;
            faddr_d = bus.trap_vector;
          end else begin
            pc_d       = bus.trap_vector;
            pend_d     = 1'b0;
            pend_tgt_d = '0;
            state_d    = S_RUN;
          end
        end else begin
          // While halted, redirects are always buffered, whatever the stall.
          if (bus.redirect_valid) begin
            if (redir_mis) begin
              fault_d = 1'b1;
              faddr_d = bus.redirect_target;
            end else begin
              pend_d     = 1'b1;
              pend_tgt_d = bus.redirect_target;
            end
          end
          if (bus.resume) state_d = S_RUN;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.pc               = pc_q;
    bus.pc_valid         = (state_q == S_RUN);
    bus.pending_redirect = pend_q;
    bus.misaligned_fault = fault_q;
    bus.fault_addr       = faddr_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed, table-driven bench for pc_sequencer. It uses XLEN = 64,
//   RESET_VECTOR = 0x1000, INC = 4 and ALIGN_BITS = 2. Each table row applies
//   one set of inputs over one clock edge, then compares the registered
//   outputs against the values in the row. Reset, boot, and async reset in the
//   middle of a stall are written out as separate sequences.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] RV = 64'h1000;

  logic clk;
  logic reset;

  pc_sequencer_if #(.XLEN(XLEN)) bus ();

  pc_sequencer #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RV),
    .INC         (4),
    .ALIGN_BITS  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            stall;
    logic            rv;
    logic [XLEN-1:0] rt;
    logic            tv;
    logic [XLEN-1:0] tvec;
    logic            halt;
    logic            res;
    logic [XLEN-1:0] e_pc;
    logic            e_valid;
    logic            e_pend;
    logic            e_fault;
    logic [XLEN-1:0] e_faddr;
  } vec_t;

  vec_t vecs[64];
  int   n_vec;
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input logic [XLEN-1:0] actual,
                       input logic [XLEN-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic add(input logic st, input logic rv, input logic [XLEN-1:0] rt,
                     input logic tv, input logic [XLEN-1:0] tvec,
                     input logic halt, input logic res,
                     input logic [XLEN-1:0] e_pc, input logic e_valid,
                     input logic e_pend, input logic e_fault,
                     input logic [XLEN-1:0] e_faddr);
    vecs[n_vec] = '{st, rv, rt, tv, tvec, halt, res,
                    e_pc, e_valid, e_pend, e_fault, e_faddr};
    n_vec++;
  endtask

  task automatic drive(input logic st, input logic rv, input logic [XLEN-1:0] rt,
                       input logic tv, input logic [XLEN-1:0] tvec,
                       input logic halt, input logic res);
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.trap_valid      = tv;
    bus.trap_vector     = tvec;
    bus.halt_req        = halt;
    bus.resume          = res;
  endtask

  task automatic check_all(input string tag, input logic [XLEN-1:0] e_pc,
                           input logic e_valid, input logic e_pend,
                           input logic e_fault, input logic [XLEN-1:0] e_faddr);
    check({tag, " pc"}, bus.pc, e_pc);
    check({tag, " pc_valid"}, XLEN'(bus.pc_valid), XLEN'(e_valid));
    check({tag, " pending"}, XLEN'(bus.pending_redirect), XLEN'(e_pend));
    check({tag, " fault"}, XLEN'(bus.misaligned_fault), XLEN'(e_fault));
    check({tag, " fault_addr"}, bus.fault_addr, e_faddr);
  endtask

  initial begin
    n_vec = 0;
    n_cmp = 0;
    n_err = 0;

    // Columns: stall rv rt tv tvec halt res | pc valid pend fault faddr
    add(0,0,0,       0,0,      0,0, 64'h1000,1,0,0,0);        // boot edge
    add(0,0,0,       0,0,      0,0, 64'h1004,1,0,0,0);
    add(0,0,0,       0,0,      0,0, 64'h1008,1,0,0,0);
    add(0,0,0,       1,64'h2000,0,0, 64'h2000,1,0,0,0);
    add(1,1,64'h3000,0,0,      0,0, 64'h2000,1,1,0,0);        // buffered
    add(1,1,64'h4000,0,0,      0,0, 64'h2000,1,1,0,0);        // overwritten
    add(1,0,0,       0,0,      0,0, 64'h2000,1,1,0,0);
    add(0,0,0,       0,0,      0,0, 64'h4000,1,0,0,0);        // pending applied
    add(0,0,0,       0,0,      0,0, 64'h4004,1,0,0,0);
    add(1,1,64'h6000,0,0,      0,0, 64'h4004,1,1,0,0);
    add(1,0,0,       1,64'h8000,0,0, 64'h8000,1,0,0,0);       // trap beats stall
    add(0,1,64'h5002,0,0,      0,0, 64'h8000,1,0,1,64'h5002); // misaligned
    add(0,0,0,       0,0,      0,0, 64'h8004,1,0,0,64'h5002); // pulse ends
    add(1,1,64'h7000,0,0,      0,0, 64'h8004,1,1,0,64'h5002);
    add(1,1,64'h7001,0,0,      0,0, 64'h8004,1,1,1,64'h7001); // buffer kept
    add(1,0,0,       1,64'h9003,0,0, 64'h8004,1,1,1,64'h9003);// bad trap
    add(0,0,0,       0,0,      0,0, 64'h7000,1,0,0,64'h9003);
    add(0,1,64'hA000,0,0,      0,0, 64'hA000,1,0,0,64'h9003);
    add(0,0,0,       0,0,      0,0, 64'hA004,1,0,0,64'h9003);
    add(0,0,0,       1,64'h0FC,0,0, 64'h00FC,1,0,0,64'h9003);
    add(0,0,0,       0,0,      0,0, 64'h0100,1,0,0,64'h9003);
    add(0,0,0,       0,0,      1,0, 64'h0104,0,0,0,64'h9003); // enter HALT
    add(0,1,64'h200, 0,0,      0,0, 64'h0104,0,1,0,64'h9003);
    add(1,0,0,       0,0,      0,0, 64'h0104,0,1,0,64'h9003);
    add(0,0,0,       0,0,      0,1, 64'h0104,1,1,0,64'h9003); // resume
    add(0,0,0,       0,0,      0,0, 64'h0200,1,0,0,64'h9003);
    add(0,0,0,       0,0,      0,0, 64'h0204,1,0,0,64'h9003);
    add(0,0,0,       1,64'h300,1,0, 64'h0300,1,0,0,64'h9003); // trap beats halt
    add(0,0,0,       0,0,      0,0, 64'h0304,1,0,0,64'h9003);
    add(0,0,0,       0,0,      1,0, 64'h0308,0,0,0,64'h9003);
    add(0,0,0,       1,64'h400,0,1, 64'h0400,1,0,0,64'h9003); // trap in HALT
    add(0,0,0,       0,0,      0,0, 64'h0404,1,0,0,64'h9003);
    add(0,1,64'h500, 0,0,      1,0, 64'h0500,0,0,0,64'h9003); // redirect+halt
    add(0,0,0,       0,0,      0,1, 64'h0500,1,0,0,64'h9003);
    add(0,0,0,       0,0,      0,0, 64'h0504,1,0,0,64'h9003);
    add(0,0,0,       1,64'hFFFF_FFFF_FFFF_FFFC,0,0,
        64'hFFFF_FFFF_FFFF_FFFC,1,0,0,64'h9003);
    add(0,0,0,       0,0,      0,0, 64'h0000,1,0,0,64'h9003); // wrap
    add(0,0,0,       0,0,      0,0, 64'h0004,1,0,0,64'h9003);
    add(1,0,0,       0,0,      0,0, 64'h0004,1,0,0,64'h9003); // plain stall

    // Reset with no clock edge needed
    drive(0,0,0,0,0,0,0);
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_all("reset", RV, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    check_all("reset held", RV, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;

    // Main table
    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].rt, vecs[i].tv, vecs[i].tvec,
            vecs[i].halt, vecs[i].res);
      @(posedge clk); #1;
      check_all($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                vecs[i].e_pend, vecs[i].e_fault, vecs[i].e_faddr);
    end

    // Async reset during a stall, with a redirect buffered
    drive(1,1,64'h600,0,0,0,0);
    @(posedge clk); #1;
    check_all("pre-reset", 64'h4, 1'b1, 1'b1, 1'b0, 64'h9003);
    drive(1,0,0,0,0,0,0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check_all("async reset", RV, 1'b0, 1'b0, 1'b0, '0);
    drive(0,0,0,0,0,0,0);
    @(posedge clk); #1;
    check_all("reset hold", RV, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("reboot", RV, 1'b1, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    check_all("reboot+1", RV + 64'h4, 1'b1, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the fetch-stage program counter register. It holds the fetch PC and computes the next PC from a prioritised set of sources: trap vector, branch/jump redirect, buffered redirect, and sequential increment. It buffers redirects that arrive while the fetch stage is stalled, and supports halt/resume and target-misalignment detection. It sits at the head of InstructionFetch, driving the instruction-memory address.

Parameters:
XLEN, 64, PC and target width in bits
RESET_VECTOR, 64'h0, PC value loaded on reset (XLEN bits)
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, number of PC LSBs that must be zero for a legal target

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold current PC (hazard/memory stall)
redirect_valid  input  1  branch/jump resolved taken this cycle
redirect_target  input  XLEN  branch/jump target address
trap_valid  input  1  exception/interrupt entry
trap_vector  input  XLEN  trap handler address
halt_req  input  1  request to stop fetching
resume  input  1  leave HALT
pc  output  XLEN  current fetch PC
pc_valid  output  1  pc is a legitimate fetch address this cycle
pending_redirect  output  1  a buffered redirect is waiting for stall release
misaligned_fault  output  1  one-cycle pulse: rejected misaligned target
fault_addr  output  XLEN  offending target, held until the next fault

Behaviour:
- Reset (async assert, any time, including mid-halt or mid-stall):
  - pc = RESET_VECTOR, pc_valid = 0, state = BOOT.
  - pending_redirect = 0, pending target = 0.
  - misaligned_fault = 0, fault_addr = 0.
- States are BOOT, RUN and HALT.
  - BOOT: the first clk edge after reset deassertion goes to RUN. pc stays RESET_VECTOR and pc_valid becomes 1, so the first fetch is at RESET_VECTOR.
  - RUN: pc_valid = 1. The next-PC priority list below applies.
  - HALT: pc_valid = 0 and pc is held.
- Next-PC priority in RUN, evaluated each edge:
  1. trap_valid: pc <= trap_vector, ignoring stall. Pending buffer is cleared.
  2. redirect_valid and not stall: pc <= redirect_target. Pending buffer is cleared; a new redirect supersedes any older buffered one.
  3. redirect_valid and stall: pc is held. Target is written into the pending buffer and pending_redirect = 1. The latest redirect overwrites any earlier buffered one.
  4. pending_redirect and not stall: pc <= pending target, pending_redirect <= 0.
  5. not stall: pc <= pc + INC, modulo 2^XLEN (wraps to 0, no flag).
  6. stall: pc is held.
- Misalignment:
  - Applies to any redirect_target or trap_vector whose low ALIGN_BITS are nonzero, checked when it is selected (priority 1, 2) or captured (priority 3).
  - The target is not applied or buffered. pc holds and the pending buffer is unchanged.
  - misaligned_fault = 1 for exactly one cycle. fault_addr <= the offending target.
  - Next-lower priorities are not evaluated that cycle.
- HALT transitions:
  - RUN -> HALT when halt_req = 1 and trap_valid = 0 at the edge. Any redirect in that same cycle is still processed per the priority list, then the state becomes HALT.
  - In HALT, redirect_valid captures into the pending buffer regardless of stall.
  - HALT -> RUN on resume = 1. pc_valid = 1 the next cycle. A buffered redirect is applied on the first non-stalled RUN edge.
  - trap_valid in HALT: pc <= trap_vector, pending buffer cleared, state -> RUN. This has priority over resume.
  - trap_valid and halt_req together: the trap wins, state stays RUN, and halt_req must be re-asserted.
- All outputs are registered; no combinational path from inputs to pc.

Test Plan:
- Reset then release, with RESET_VECTOR = 0x1000 and stall = 0 -> pc_valid rises after 1 edge; pc sequence is 0x1000, 0x1004, 0x1008.
- pc = 0x2000, stall held for 3 cycles; redirect_valid with target 0x3000 in cycle 1, then target 0x4000 in cycle 2 -> pc stays 0x2000 and pending_redirect = 1; first unstalled edge gives pc = 0x4000, then pending_redirect = 0 and pc = 0x4004.
- trap_valid with trap_vector 0x8000 while stall = 1 and a pending redirect exists -> pc = 0x8000 next edge; pending_redirect = 0.
- redirect_target 0x5002 with ALIGN_BITS = 2 -> pc unchanged; misaligned_fault pulses exactly 1 cycle; fault_addr = 0x5002.
- halt_req at pc = 0x100 -> pc_valid = 0 and pc holds 0x104. A redirect to 0x200 during HALT sets pending_redirect. resume -> pc_valid = 1 with pc = 0x104, then pc = 0x200 on the next edge.
- pc = 2^XLEN − 4, run 1 edge -> pc = 0. Assert reset asynchronously mid-stall -> pc = RESET_VECTOR and pc_valid = 0 immediately, with no clock edge required.
